// File: rtl/machine_timer_pkg.sv
// machine_timer shared types: register offsets, reset values and the
// register-window decoder used by the CLINT-style machine timer.
package machine_timer_pkg;

   localparam logic [7:0] CLINT_MSIP_OFS        = 8'h00;
   localparam logic [7:0] CLINT_MTIMECMP_LO_OFS = 8'h08;
   localparam logic [7:0] CLINT_MTIMECMP_HI_OFS = 8'h0C;
   localparam logic [7:0] CLINT_MTIME_LO_OFS    = 8'h10;
   localparam logic [7:0] CLINT_MTIME_HI_OFS    = 8'h14;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_TIME_LO,
      REG_TIME_HI
   } reg_sel_e;

   // word is the byte offset with its two low bits dropped
   function automatic reg_sel_e reg_decode(input logic [5:0] word);
      reg_sel_e s;
      unique case (1'b1)
         (word == CLINT_MSIP_OFS[7:2]):        s = REG_MSIP;
         (word == CLINT_MTIMECMP_LO_OFS[7:2]): s = REG_CMP_LO;
         (word == CLINT_MTIMECMP_HI_OFS[7:2]): s = REG_CMP_HI;
         (word == CLINT_MTIME_LO_OFS[7:2]):    s = REG_TIME_LO;
         (word == CLINT_MTIME_HI_OFS[7:2]):    s = REG_TIME_HI;
         default:                              s = REG_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/machine_timer_if.sv
// machine_timer bus interface: single-cycle request, registered ack.
// req_i/we_i/addr_i/wdata_i from master; ack_o/rdata_o from slave.
interface machine_timer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  req_i;
   logic                  we_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  ack_o;
   logic [DATA_WIDTH-1:0] rdata_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  ack_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output ack_o, rdata_o
   );
endinterface

// File: rtl/timer_prescaler.sv
// mtime prescaler: counts 0..PRESCALE-1, tick_o on wrap, frozen on halt.
// Ports: clk_i, rst_i (async active-low), halt_i in; tick_o out.
module timer_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic halt_i,
   output logic tick_o
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] cnt;

   assign tick_o = ~halt_i & (cnt == LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt <= '0;
      end else if (!halt_i) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
      end
   end

endmodule

// File: rtl/machine_timer.sv
// CLINT-style machine timer: mtime, mtimecmp, msip and their mip lines.
// Ports: clk_i, rst_i (async active-low), bus (slave), halt_i; mip_*_o.
module machine_timer
   import machine_timer_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 5,
   parameter int unsigned PRESCALE   = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   machine_timer_if.slave  bus,
   input  logic            halt_i,
   output logic            mip_timer_o,
   output logic            mip_sw_o
);

   logic [63:0]           mtime, mtime_nxt;
   logic [63:0]           mtimecmp, cmp_nxt;
   logic [31:0]           hi_snap;
   logic                  msip;
   logic                  tick;
   logic                  wr, rd;
   reg_sel_e              sel;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                  ack_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  mtip_q, msip_q;
   logic                  unused_addr;

   // byte lanes are not decoded
   assign unused_addr = ^bus.addr_i[1:0];

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .halt_i (halt_i),
      .tick_o (tick)
   );

   assign sel = reg_decode(6'(bus.addr_i[ADDR_WIDTH-1:2]));
   assign wr  = bus.req_i & bus.we_i;
   assign rd  = bus.req_i & ~bus.we_i;

   // a write to either half replaces this edge's increment
   always_comb begin
      mtime_nxt = mtime;
      if (wr && sel == REG_TIME_LO)
         mtime_nxt = {mtime[63:32], bus.wdata_i};
      else if (wr && sel == REG_TIME_HI)
         mtime_nxt = {bus.wdata_i, mtime[31:0]};
      else if (tick)
         mtime_nxt = mtime + 64'd1;
   end

   always_comb begin
      cmp_nxt = mtimecmp;
      if (wr && sel == REG_CMP_LO)
         cmp_nxt = {mtimecmp[63:32], bus.wdata_i};
      else if (wr && sel == REG_CMP_HI)
         cmp_nxt = {bus.wdata_i, mtimecmp[31:0]};
   end

   // MTIME_HI returns the half captured by the last MTIME_LO read
   always_comb begin
      rd_mux = '0;
      unique case (sel)
         REG_MSIP:    rd_mux = {{(DATA_WIDTH-1){1'b0}}, msip};
         REG_CMP_LO:  rd_mux = mtimecmp[31:0];
         REG_CMP_HI:  rd_mux = mtimecmp[63:32];
         REG_TIME_LO: rd_mux = mtime[31:0];
         REG_TIME_HI: rd_mux = hi_snap;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mtime    <= '0;
         mtimecmp <= MTIMECMP_RESET;
         msip     <= 1'b0;
         hi_snap  <= '0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         mtip_q   <= 1'b0;
         msip_q   <= 1'b0;
      end else begin
         mtime    <= mtime_nxt;
         mtimecmp <= cmp_nxt;
         if (wr && sel == REG_MSIP)
            msip <= bus.wdata_i[0];
         if (rd && sel == REG_TIME_LO)
            hi_snap <= mtime[63:32];
         ack_q   <= bus.req_i;
         rdata_q <= rd ? rd_mux : '0;
         mtip_q  <= (mtime >= mtimecmp);
         msip_q  <= msip;
      end
   end

   assign bus.ack_o   = ack_q;
   assign bus.rdata_o = rdata_q;
   assign mip_timer_o = mtip_q;
   assign mip_sw_o    = msip_q;

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- Memory-mapped machine timer and software-interrupt source (CLINT-style) for the single-hart core.
- Owns a 64-bit mtime counter, a 64-bit mtimecmp register and the msip bit.
- Drives the timer-pending and software-pending lines into the interrupt controller, which feed mip.MTIP and mip.MSIP.
- Slave on the data-memory bus; a registered one-cycle request/ack handshake.

Parameters:
- DATA_WIDTH, 32, bus data width; fixed at 32.
- ADDR_WIDTH, 5, byte-offset width of the register window.
- PRESCALE, 1, core clocks per mtime increment; legal range 1..65535.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-low reset
- req_i  in  1  bus access request, single-cycle pulse
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  byte offset within the window
- wdata_i  in  DATA_WIDTH  write data
- ack_o  out  1  access complete
- rdata_o  out  DATA_WIDTH  read data, valid while ack_o = 1
- halt_i  in  1  freeze mtime (debug halt)
- mip_timer_o  out  1  timer interrupt pending
- mip_sw_o  out  1  software interrupt pending

Behaviour:
- Register map (word aligned; addr_i[1:0] ignored):
  - 0x00 MSIP: bit0 = msip, other bits read 0.
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 MTIME_LO
  - 0x14 MTIME_HI
  - Any other offset: write ignored, read returns 0, ack still given.
- Reset (rst_i = 0, asynchronous):
  - mtime = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF, msip = 0, prescale counter = 0, hi snapshot = 0.
  - ack_o = 0, rdata_o = 0, mip_timer_o = 0, mip_sw_o = 0.
  - Reset mid-access: the access is dropped and no ack is issued.
- Handshake:
  - req_i sampled at posedge N; ack_o = 1 for exactly the cycle after (N+1); rdata_o is registered with it.
  - Writes take effect at edge N.
  - Back-to-back requests on consecutive cycles are legal; each gets its own ack.
  - rdata_o = 0 for writes and whenever ack_o = 0.
- Prescaler:
  - A 16-bit counter counts 0..PRESCALE-1 and emits a tick on wrap.
  - PRESCALE = 1 gives a tick every cycle.
  - Counter holds while halt_i = 1.
- mtime:
  - Increments by 1 on each tick; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A bus write to either half at the same edge as a tick wins: the written value is loaded and the increment is lost for that edge.
  - A write to one half leaves the other half unchanged; no carry is applied from the write.
- Tear-free read:
  - Reading MTIME_LO also latches mtime[63:32] (same-edge value) into a hi snapshot.
  - Reading MTIME_HI returns the snapshot, not the live value.
  - Reading MTIMECMP halves returns live values.
- mip_timer_o:
  - Registered (mtime >= mtimecmp), 64-bit unsigned compare using post-update values.
  - Visible one cycle after mtime or mtimecmp changes.
  - Writing mtimecmp above mtime deasserts it on the following edge.
- mip_sw_o: registered copy of msip, set and cleared only by bus writes to MSIP.
- Simultaneous events: a write to MTIMECMP in the same cycle mtime reaches the old compare value follows the same post-update rule (new compare value is used).

Decomposition:
- Shared defines header (alongside DATA_WIDTH and RESET_ENABLE) gains the register offsets:
  - `CLINT_MSIP_OFS, `CLINT_MTIMECMP_LO_OFS, `CLINT_MTIMECMP_HI_OFS, `CLINT_MTIME_LO_OFS, `CLINT_MTIME_HI_OFS.
  - `MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF.
- One natural sub-module: timer_prescaler (counter + tick + halt).
- Register decode, mtime, compare and bus response stay in machine_timer.

Test Plan:
- Reset release, PRESCALE=1, idle 10 cycles -> MTIME_LO read = 10 ±1 per handshake timing; mip_timer_o = 0; mip_sw_o = 0; MTIMECMP_HI read = 0xFFFF_FFFF.
- Write MTIMECMP_HI = 0, MTIMECMP_LO = 20 at mtime ≈ 5 -> mip_timer_o rises exactly one cycle after mtime reaches 20; then write MTIMECMP_LO = 100 -> mip_timer_o = 0 on the next edge.
- Write MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE, then read LO then HI -> LO = 0xFFFF_FFFF (or 0x0000_0000) with HI snapshot consistent (0 or 1 respectively), never mixed.
- Write MSIP = 1 -> mip_sw_o = 1 next cycle; write MSIP = 0 -> mip_sw_o = 0 next cycle; bit1 written 1 reads back 0.
- PRESCALE=4, halt_i = 1 for 8 cycles mid-run -> mtime advances 0 during halt and 1 per 4 cycles otherwise.
- Read offset 0x1C -> ack_o = 1 one cycle after req, rdata_o = 0; assert rst_i low mid-request -> no ack, all outputs 0 immediately.
